// File: rtl/cabac_engine_ctrl_pkg.sv
// Shared constants, state encoding and LPS range table for the CABAC regular-bin engine.
// bin_pstate packing: [7:1] = pStateIdx (values above 62 behave as 62), [0] = valMPS.
package cabac_defs;

  localparam logic [8:0]        CABAC_INIT_RANGE = 9'd510;
  localparam logic signed [3:0] CABAC_BN_INIT    = -4'sd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT0  = 3'd1,
    ST_INIT1  = 3'd2,
    ST_READY  = 3'd3,
    ST_REFILL = 3'd4
  } eng_state_e;

  // rangeTabLPS indexed by {pStateIdx, range[7:6]}
  localparam logic [7:0] CABAC_LPS_TAB [256] = '{
    8'd128, 8'd176, 8'd208, 8'd240, 8'd128, 8'd167, 8'd197, 8'd227, 8'd128, 8'd158, 8'd187, 8'd216, 8'd123, 8'd150, 8'd178, 8'd205,
    8'd116, 8'd142, 8'd169, 8'd195, 8'd111, 8'd135, 8'd160, 8'd185, 8'd105, 8'd128, 8'd152, 8'd175, 8'd100, 8'd122, 8'd144, 8'd166,
    8'd95,  8'd116, 8'd137, 8'd158, 8'd90,  8'd110, 8'd130, 8'd150, 8'd85,  8'd104, 8'd123, 8'd142, 8'd81,  8'd99,  8'd117, 8'd135,
    8'd77,  8'd94,  8'd111, 8'd128, 8'd73,  8'd89,  8'd105, 8'd122, 8'd69,  8'd85,  8'd100, 8'd116, 8'd66,  8'd80,  8'd95,  8'd110,
    8'd62,  8'd76,  8'd90,  8'd104, 8'd59,  8'd72,  8'd86,  8'd99,  8'd56,  8'd69,  8'd81,  8'd94,  8'd53,  8'd65,  8'd77,  8'd89,
    8'd51,  8'd62,  8'd73,  8'd85,  8'd48,  8'd59,  8'd69,  8'd80,  8'd46,  8'd56,  8'd66,  8'd76,  8'd43,  8'd53,  8'd63,  8'd72,
    8'd41,  8'd50,  8'd59,  8'd69,  8'd39,  8'd48,  8'd56,  8'd65,  8'd37,  8'd45,  8'd54,  8'd62,  8'd35,  8'd43,  8'd51,  8'd59,
    8'd33,  8'd41,  8'd48,  8'd56,  8'd32,  8'd39,  8'd46,  8'd53,  8'd30,  8'd37,  8'd43,  8'd50,  8'd29,  8'd35,  8'd41,  8'd48,
    8'd27,  8'd33,  8'd39,  8'd45,  8'd26,  8'd31,  8'd37,  8'd43,  8'd24,  8'd30,  8'd35,  8'd41,  8'd23,  8'd28,  8'd33,  8'd39,
    8'd22,  8'd27,  8'd32,  8'd37,  8'd21,  8'd26,  8'd30,  8'd35,  8'd20,  8'd24,  8'd29,  8'd33,  8'd19,  8'd23,  8'd27,  8'd31,
    8'd18,  8'd22,  8'd26,  8'd30,  8'd17,  8'd21,  8'd25,  8'd28,  8'd16,  8'd20,  8'd23,  8'd27,  8'd15,  8'd19,  8'd22,  8'd25,
    8'd14,  8'd18,  8'd21,  8'd24,  8'd14,  8'd17,  8'd20,  8'd23,  8'd13,  8'd16,  8'd19,  8'd22,  8'd12,  8'd15,  8'd18,  8'd21,
    8'd12,  8'd14,  8'd17,  8'd20,  8'd11,  8'd14,  8'd16,  8'd19,  8'd11,  8'd13,  8'd15,  8'd18,  8'd10,  8'd12,  8'd15,  8'd17,
    8'd10,  8'd12,  8'd14,  8'd16,  8'd9,   8'd11,  8'd13,  8'd15,  8'd9,   8'd11,  8'd12,  8'd14,  8'd8,   8'd10,  8'd12,  8'd14,
    8'd8,   8'd9,   8'd11,  8'd13,  8'd7,   8'd9,   8'd11,  8'd12,  8'd7,   8'd9,   8'd10,  8'd12,  8'd7,   8'd8,   8'd10,  8'd11,
    8'd6,   8'd8,   8'd9,   8'd11,  8'd6,   8'd7,   8'd9,   8'd10,  8'd6,   8'd7,   8'd8,   8'd9,   8'd2,   8'd2,   8'd2,   8'd2
  };

  // Left shifts needed to bring an LPS sub-range back to >= 256.
  function automatic logic [2:0] cabac_renorm_bits(input logic [7:0] lps);
    if (lps[7])      return 3'd1;
    else if (lps[6]) return 3'd2;
    else if (lps[5]) return 3'd3;
    else if (lps[4]) return 3'd4;
    else if (lps[3]) return 3'd5;
    else             return 3'd6;
  endfunction

endpackage

// File: rtl/cabac_engine_ctrl_decode_bin.sv
// Combinational DecodeBin: one regular-bin arithmetic decode step with renormalisation of
// range and value; byte refill is left to the caller, which receives the shift count.
module cabac_engine_ctrl_decode_bin
  import cabac_defs::*;
#(
  parameter int BIN_WIDTH = 1
) (
  input  logic [8:0]           range_i,
  input  logic [15:0]          value_i,
  input  logic [7:0]           pstate_i,
  output logic [8:0]           range_o,
  output logic [15:0]          value_o,
  output logic [2:0]           num_bits_o,
  output logic [BIN_WIDTH-1:0] bin_o,
  output logic                 lps_o
);

  logic [5:0]  state_idx;
  logic        val_mps;
  logic [7:0]  range_lps;
  logic [8:0]  range_mps;
  logic [15:0] scaled_range;
  logic [15:0] value_lps;

  always_comb begin
    state_idx    = (pstate_i[7:1] > 7'd62) ? 6'd62 : pstate_i[6:1];
    val_mps      = pstate_i[0];
    range_lps    = CABAC_LPS_TAB[{state_idx, range_i[7:6]}];
    range_mps    = range_i - {1'b0, range_lps};
    // value is kept 7 bits left of range, so compare against the scaled MPS sub-range
    scaled_range = {range_mps, 7'd0};
    value_lps    = value_i - scaled_range;
    bin_o        = '0;
    if (value_i < scaled_range) begin
      lps_o    = 1'b0;
      bin_o[0] = val_mps;
      if (range_mps[8]) begin
        num_bits_o = 3'd0;
        range_o    = range_mps;
        value_o    = value_i;
      end else begin
        num_bits_o = 3'd1;
        range_o    = {range_mps[7:0], 1'b0};
        value_o    = {value_i[14:0], 1'b0};
      end
    end else begin
      lps_o      = 1'b1;
      bin_o[0]   = ~val_mps;
      num_bits_o = cabac_renorm_bits(range_lps);
      range_o    = {1'b0, range_lps} << num_bits_o;
      value_o    = value_lps << num_bits_o;
    end
  end

endmodule

// File: rtl/cabac_engine_ctrl.sv
// CABAC regular-bin engine control: init from two bytes, one DecodeBin per accepted request,
// byte-wise refill of value when bits_needed goes non-negative.
module cabac_engine_ctrl
  import cabac_defs::*;
#(
  parameter int         BIN_WIDTH  = 1,
  parameter logic [8:0] INIT_RANGE = CABAC_INIT_RANGE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic                 bin_req,
  input  logic [7:0]           bin_pstate,
  output logic                 bin_ready,
  output logic                 bin_valid,
  output logic [BIN_WIDTH-1:0] bin_out,
  output logic                 bin_lps,
  output logic [8:0]           range_q,
  output logic [15:0]          value_q,
  output logic [2:0]           dbg_state,
  output logic [3:0]           dbg_bits_needed
);

  // Handshakes: a byte moves on a rising edge where byte_valid & byte_ready, a request is
  // taken where bin_req & bin_ready. Both readies depend only on state and start, never on
  // valid/req; start forces both low so a restart never swallows a byte or a request.

  eng_state_e                  state_q, state_d;
  logic [8:0]                  range_d;
  logic [15:0]                 value_d;
  logic signed [3:0]           bits_needed_q, bits_needed_d, bn_next;
  logic                        bin_valid_q, bin_valid_d;
  logic [BIN_WIDTH-1:0]        bin_out_q, bin_out_d;
  logic                        bin_lps_q, bin_lps_d;
  logic                        byte_hs, bin_hs;
  logic [15:0]                 refill_value;

  logic [8:0]                  dec_range;
  logic [15:0]                 dec_value;
  logic [2:0]                  dec_num_bits;
  logic [BIN_WIDTH-1:0]        dec_bin;
  logic                        dec_lps;

  cabac_engine_ctrl_decode_bin #(
    .BIN_WIDTH(BIN_WIDTH)
  ) u_decode_bin (
    .range_i    (range_q),
    .value_i    (value_q),
    .pstate_i   (bin_pstate),
    .range_o    (dec_range),
    .value_o    (dec_value),
    .num_bits_o (dec_num_bits),
    .bin_o      (dec_bin),
    .lps_o      (dec_lps)
  );

  always_comb begin
    byte_ready = 1'b0;
    bin_ready  = 1'b0;
    if (!start) begin
      byte_ready = (state_q == ST_INIT0) || (state_q == ST_INIT1) || (state_q == ST_REFILL);
      bin_ready  = (state_q == ST_READY);
    end
  end

  assign byte_hs      = byte_valid & byte_ready;
  assign bin_hs       = bin_req & bin_ready;
  assign bn_next      = bits_needed_q + $signed({1'b0, dec_num_bits});
  // bits_needed is 0..5 in REFILL; carries past bit 15 are dropped
  assign refill_value = value_q + ({8'd0, byte_in} << bits_needed_q[2:0]);

  always_comb begin
    state_d       = state_q;
    range_d       = range_q;
    value_d       = value_q;
    bits_needed_d = bits_needed_q;
    bin_valid_d   = 1'b0;
    bin_out_d     = bin_out_q;
    bin_lps_d     = bin_lps_q;
    if (start) begin
      state_d = ST_INIT0;
    end else begin
      case (state_q)
        ST_INIT0: begin
          if (byte_hs) begin
            value_d = {byte_in, value_q[7:0]};
            state_d = ST_INIT1;
          end
        end
        ST_INIT1: begin
          if (byte_hs) begin
            value_d       = {value_q[15:8], byte_in};
            range_d       = INIT_RANGE;
            bits_needed_d = CABAC_BN_INIT;
            state_d       = ST_READY;
          end
        end
        ST_READY: begin
          if (bin_hs) begin
            range_d       = dec_range;
            value_d       = dec_value;
            bits_needed_d = bn_next;
            bin_valid_d   = 1'b1;
            bin_out_d     = dec_bin;
            bin_lps_d     = dec_lps;
            state_d       = bn_next[3] ? ST_READY : ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (byte_hs) begin
            value_d       = refill_value;
            bits_needed_d = bits_needed_q - 4'sd8;
            state_d       = ST_READY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      range_q       <= INIT_RANGE;
      value_q       <= 16'd0;
      bits_needed_q <= CABAC_BN_INIT;
      bin_valid_q   <= 1'b0;
      bin_out_q     <= '0;
      bin_lps_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      range_q       <= range_d;
      value_q       <= value_d;
      bits_needed_q <= bits_needed_d;
      bin_valid_q   <= bin_valid_d;
      bin_out_q     <= bin_out_d;
      bin_lps_q     <= bin_lps_d;
    end
  end

  assign bin_valid       = bin_valid_q;
  assign bin_out         = bin_out_q;
  assign bin_lps         = bin_lps_q;
  assign dbg_state       = state_q;
  assign dbg_bits_needed = bits_needed_q;

endmodule

// File: tb/tb_cabac_engine_ctrl.sv
// Bench for cabac_engine_ctrl: directed init/MPS/LPS/refill/restart/reset cases, then random bins
// scored against an integer-arithmetic CABAC decoder model fed from the same byte stream.
module tb_cabac_engine_ctrl;
  import cabac_defs::*;

  localparam int W        = 31;
  localparam int N_BINS   = 10000;
  localparam int STREAM_N = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, byte_valid, bin_req;
  logic [7:0]  byte_in, bin_pstate;
  logic        byte_ready, bin_ready, bin_valid, bin_lps;
  logic [0:0]  bin_out;
  logic [8:0]  range_q;
  logic [15:0] value_q;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_bits_needed;

  int errors = 0;
  int checks = 0;
  int excl_viol = 0;
  int bins_done = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   stream [STREAM_N];
  int           drv_ptr = 0;
  int           m_ptr, m_range, m_value, m_bn;

  int lps_t [256] = '{
    128,176,208,240, 128,167,197,227, 128,158,187,216, 123,150,178,205,
    116,142,169,195, 111,135,160,185, 105,128,152,175, 100,122,144,166,
    95,116,137,158, 90,110,130,150, 85,104,123,142, 81,99,117,135,
    77,94,111,128, 73,89,105,122, 69,85,100,116, 66,80,95,110,
    62,76,90,104, 59,72,86,99, 56,69,81,94, 53,65,77,89,
    51,62,73,85, 48,59,69,80, 46,56,66,76, 43,53,63,72,
    41,50,59,69, 39,48,56,65, 37,45,54,62, 35,43,51,59,
    33,41,48,56, 32,39,46,53, 30,37,43,50, 29,35,41,48,
    27,33,39,45, 26,31,37,43, 24,30,35,41, 23,28,33,39,
    22,27,32,37, 21,26,30,35, 20,24,29,33, 19,23,27,31,
    18,22,26,30, 17,21,25,28, 16,20,23,27, 15,19,22,25,
    14,18,21,24, 14,17,20,23, 13,16,19,22, 12,15,18,21,
    12,14,17,20, 11,14,16,19, 11,13,15,18, 10,12,15,17,
    10,12,14,16, 9,11,13,15, 9,11,12,14, 8,10,12,14,
    8,9,11,13, 7,9,11,12, 7,9,10,12, 7,8,10,11,
    6,8,9,11, 6,7,9,10, 6,7,8,9, 2,2,2,2
  };

  cabac_engine_ctrl #(.BIN_WIDTH(1), .INIT_RANGE(9'd510)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .bin_req         (bin_req),
    .bin_pstate      (bin_pstate),
    .bin_ready       (bin_ready),
    .bin_valid       (bin_valid),
    .bin_out         (bin_out),
    .bin_lps         (bin_lps),
    .range_q         (range_q),
    .value_q         (value_q),
    .dbg_state       (dbg_state),
    .dbg_bits_needed (dbg_bits_needed)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_bin_ready"}, bin_ready, 0);
    check({tag, "_bin_valid"}, bin_valid, 0);
    check({tag, "_bin_out"}, bin_out, 0);
    check({tag, "_bin_lps"}, bin_lps, 0);
    check({tag, "_range"}, range_q, 510);
    check({tag, "_value"}, value_q, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    check({tag, "_bits_needed"}, dbg_bits_needed, 4'h8);
  endtask

  // ---------------- reference model ----------------
  // Engine (re)initialisation takes the next two bytes the DUT has not consumed yet.
  function automatic void model_init();
    m_ptr   = drv_ptr;
    m_value = (int'(stream[m_ptr]) << 8) | int'(stream[m_ptr + 1]);
    m_ptr   = m_ptr + 2;
    m_range = 510;
    m_bn    = -8;
  endfunction

  function automatic void model_decode(input logic [7:0] ps);
    int idx, q, lps, rmps, mps, bin, is_lps, nb;
    logic [W-1:0] e;
    idx = int'(ps[7:1]);
    if (idx > 62) idx = 62;
    mps  = int'(ps[0]);
    q    = (m_range / 64) % 4;
    lps  = lps_t[idx * 4 + q];
    rmps = m_range - lps;
    if (m_value < rmps * 128) begin
      is_lps  = 0;
      bin     = mps;
      m_range = rmps;
    end else begin
      is_lps  = 1;
      bin     = 1 - mps;
      m_value = m_value - rmps * 128;
      m_range = lps;
    end
    nb = 0;
    while (m_range < 256) begin
      m_range = m_range * 2;
      m_value = (m_value * 2) % 65536;
      nb++;
    end
    m_bn = m_bn + nb;
    e = {bin[0], is_lps[0], m_bn[3:0], m_range[8:0], m_value[15:0]};
    exp_q.push_back(e);
    if (m_bn >= 0) begin
      m_value = (m_value + (int'(stream[m_ptr]) << m_bn)) % 65536;
      m_ptr++;
      m_bn = m_bn - 8;
    end
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next rising edge.
  task automatic drive(input bit st, input bit bv, input bit rq, input logic [7:0] ps);
    bit byte_hs, bin_hs;
    start      = st;
    byte_valid = bv;
    byte_in    = stream[drv_ptr];
    bin_req    = rq;
    bin_pstate = ps;
    #1;
    byte_hs = bv && byte_ready;
    bin_hs  = rq && bin_ready;
    if (bin_hs) begin
      model_decode(ps);
      bins_done++;
    end
    if (st) model_init();
    @(posedge clk);
    #1;
    if (byte_hs) drv_ptr++;
    start      = 1'b0;
    byte_valid = 1'b0;
    bin_req    = 1'b0;
  endtask

  task automatic init_engine(input logic [7:0] b0, input logic [7:0] b1);
    stream[drv_ptr]     = b0;
    stream[drv_ptr + 1] = b1;
    drive(1, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
  endtask

  function automatic logic [7:0] rand_ps();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return {1'b0, 6'($urandom_range(0, 62)), 1'($urandom_range(0, 1))};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_ready && bin_ready) excl_viol++;
      if (bin_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bin: got bin_valid=1 expected no pending request");
        end else begin
          check("bin_result", {1'b0, bin_out[0], bin_lps, dbg_bits_needed, range_q, value_q},
                {1'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; bin_req = 1'b0; bin_pstate = 8'h00;
    for (int i = 0; i < STREAM_N; i++) stream[i] = 8'($urandom_range(0, 255));
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Init from 0x12, 0x34; start cycle itself must not take a byte
    stream[drv_ptr] = 8'h12;
    stream[drv_ptr + 1] = 8'h34;
    drive(1, 1, 0, 8'h00);
    check("init_state0", dbg_state, ST_INIT0);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    check("init_bin_ready", bin_ready, 1);
    check("init_byte_ready", byte_ready, 0);
    check("init_value", value_q, 16'h1234);
    check("init_range", range_q, 510);
    check("init_bits_needed", dbg_bits_needed, 4'h8);

    // MPS without renorm: pStateIdx 0, valMPS 1 -> LPS 240, range 270
    init_engine(8'h00, 8'h00);
    drive(0, 0, 1, 8'h01);
    check("mps_range", range_q, 270);
    check("mps_value", value_q, 16'h0000);
    check("mps_state", dbg_state, ST_READY);
    check("mps_bits_needed", dbg_bits_needed, 4'h8);

    // LPS chain from 0xFF00 ending in REFILL with bits_needed = 2
    init_engine(8'hFF, 8'h00);
    stream[drv_ptr] = 8'hAB;
    drive(0, 0, 1, 8'h00);
    check("lps1_range", range_q, 480);
    check("lps1_value", value_q, 16'hF000);
    check("lps1_bits_needed", dbg_bits_needed, 4'h9);
    check("lps1_bin", {bin_out, bin_lps}, 2'b11);
    drive(0, 0, 1, 8'h7C);
    check("lps2_range", range_q, 288);
    check("lps2_value", value_q, 16'h9000);
    drive(0, 0, 1, 8'h3C);
    check("lps3_state", dbg_state, ST_REFILL);
    check("lps3_bits_needed", dbg_bits_needed, 4'h2);

    // Refill stall: no byte for 5 cycles while a request is held
    repeat (5) drive(0, 0, 1, 8'h01);
    check("stall_bin_ready", bin_ready, 0);
    check("stall_byte_ready", byte_ready, 1);
    check("stall_range", range_q, 480);
    check("stall_value", value_q, 16'hF000);
    check("stall_bits_needed", dbg_bits_needed, 4'h2);
    drive(0, 1, 0, 8'h00);
    check("refill_value", value_q, 16'hF2AC);
    check("refill_bits_needed", dbg_bits_needed, 4'hA);
    check("refill_state", dbg_state, ST_READY);

    // Restart while in REFILL with a byte offered: byte stays for INIT0
    stream[drv_ptr] = 8'h55;
    stream[drv_ptr + 1] = 8'h66;
    drive(0, 0, 1, 8'h7C);
    drive(0, 0, 1, 8'h7C);
    check("restart_pre_state", dbg_state, ST_REFILL);
    start = 1'b1; byte_valid = 1'b1; byte_in = stream[drv_ptr];
    #1;
    check("restart_byte_ready", byte_ready, 0);
    check("restart_bin_ready", bin_ready, 0);
    model_init();
    @(posedge clk);
    #1;
    start = 1'b0; byte_valid = 1'b0;
    check("restart_state", dbg_state, ST_INIT0);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    check("restart_value", value_q, 16'h5566);

    // Random traffic, then async reset asserted between edges
    for (int i = 0; i < 300; i++)
      drive(0, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 80, rand_ps());
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 1, 0, 8'h00);

    // Long random run including rare restarts
    bins_done = 0;
    cyc = 0;
    while (bins_done < N_BINS && cyc < 80000) begin
      drive($urandom_range(0, 2999) == 0, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 80, rand_ps());
      cyc++;
    end
    check("bins_within_budget", bins_done >= N_BINS, 1);
    repeat (3) drive(0, 0, 0, 8'h00);
    check("scoreboard_drained", exp_q.size(), 0);
    check("ready_exclusive", excl_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
